// File: rtl/branch_predictor_btb_if.sv
// Fetch/resolve bus between the pipeline (master) and the branch predictor (slave).
// update_en is a one-cycle valid with no ready: the predictor accepts every pulse.
interface branch_predictor_btb_if #(
  parameter int XLEN      = 64,
  parameter int STAT_BITS = 32
);
  logic [XLEN-1:0]      lookup_pc;
  logic                 pred_hit;
  logic                 pred_taken;
  logic [XLEN-1:0]      pred_target;
  logic                 update_en;
  logic [XLEN-1:0]      update_pc;
  logic                 update_taken;
  logic [XLEN-1:0]      update_target;
  logic                 update_mispredict;
  logic [STAT_BITS-1:0] update_count;
  logic [STAT_BITS-1:0] mispredict_count;

  modport master (
    output lookup_pc, update_en, update_pc, update_taken, update_target, update_mispredict,
    input  pred_hit, pred_taken, pred_target, update_count, mispredict_count
  );

  modport slave (
    input  lookup_pc, update_en, update_pc, update_taken, update_target, update_mispredict,
    output pred_hit, pred_taken, pred_target, update_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters; zero-latency lookup for IF,
// single-cycle update from ID-stage branch resolution, plus saturating statistics.
module branch_predictor_btb #(
  parameter int XLEN      = 64,
  parameter int ENTRIES   = 16,
  parameter int TAG_BITS  = 10,
  parameter int CTR_BITS  = 2,
  parameter int STAT_BITS = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_predictor_btb_if.slave bus
);
  localparam int IDX = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0]  CTR_WNT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]  CTR_WT   = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic                 valid_q [ENTRIES];
  logic [TAG_BITS-1:0]  tag_q   [ENTRIES];
  logic [XLEN-1:0]      tgt_q   [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_q   [ENTRIES];
  logic [STAT_BITS-1:0] upd_cnt_q;
  logic [STAT_BITS-1:0] mis_cnt_q;

  logic [IDX-1:0]      lk_idx;
  logic [IDX-1:0]      up_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [TAG_BITS-1:0] up_tag;
  logic                lk_hit;
  logic                lk_taken;
  logic                up_hit;
  logic                unused_pc_bits;

  assign lk_idx = bus.lookup_pc[IDX+1:2];
  assign lk_tag = bus.lookup_pc[IDX+TAG_BITS+1:IDX+2];
  assign up_idx = bus.update_pc[IDX+1:2];
  assign up_tag = bus.update_pc[IDX+TAG_BITS+1:IDX+2];
  assign unused_pc_bits = ^bus.update_pc;

  // Lookup reads only registered state, so a same-cycle update is never bypassed.
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign bus.pred_hit         = lk_hit;
  assign bus.pred_taken       = lk_taken;
  assign bus.pred_target      = lk_taken ? tgt_q[lk_idx] : bus.lookup_pc + XLEN'(4);
  assign bus.update_count     = upd_cnt_q;
  assign bus.mispredict_count = mis_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (bus.update_en) begin
      if (up_hit) begin
        if (bus.update_taken) begin
          tgt_q[up_idx] <= bus.update_target;
          if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
        end
      end else if (bus.update_taken) begin
        // Allocation evicts whatever entry aliases on this index.
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= bus.update_target;
        ctr_q[up_idx]   <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else if (bus.update_en) begin
      if (upd_cnt_q != STAT_MAX) upd_cnt_q <= upd_cnt_q + STAT_BITS'(1);
      if (bus.update_mispredict && (mis_cnt_q != STAT_MAX)) mis_cnt_q <= mis_cnt_q + STAT_BITS'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: two instances (32-bit and 4-bit statistics) share
// the same stimulus and are compared against an entry-level reference model.
module tb_branch_predictor_btb;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_btb_if #(.XLEN(XLEN), .STAT_BITS(32)) bus_a ();
  branch_predictor_btb_if #(.XLEN(XLEN), .STAT_BITS(4))  bus_b ();

  branch_predictor_btb #(.XLEN(XLEN), .ENTRIES(16), .TAG_BITS(10), .CTR_BITS(2), .STAT_BITS(32))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  branch_predictor_btb #(.XLEN(XLEN), .ENTRIES(16), .TAG_BITS(10), .CTR_BITS(2), .STAT_BITS(4))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // reference model: per-entry state as plain integers
  bit              m_valid [16];
  int              m_tag   [16];
  logic [XLEN-1:0] m_tgt   [16];
  int              m_ctr   [16];
  longint          m_upd;
  longint          m_mis;

  logic [65:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int pc_idx(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int pc_tag(input logic [XLEN-1:0] pc);
    return int'((pc / 64) % 1024);
  endfunction

  function automatic longint sat(input longint v, input longint max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_upd = 0;
    m_mis = 0;
  endtask

  task automatic model_update(input logic [XLEN-1:0] pc, input logic tk,
                              input logic [XLEN-1:0] tgt, input logic mis);
    int i;
    i = pc_idx(pc);
    if (m_valid[i] && m_tag[i] == pc_tag(pc)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc_tag(pc);
      m_tgt[i]   = tgt;
      m_ctr[i]   = 2;
    end
    m_upd++;
    if (mis) m_mis++;
  endtask

  function automatic logic [65:0] model_predict(input logic [XLEN-1:0] pc);
    logic hit, tk;
    logic [XLEN-1:0] t;
    int i;
    i   = pc_idx(pc);
    hit = m_valid[i] && (m_tag[i] == pc_tag(pc));
    tk  = hit && (m_ctr[i] >= 2);
    t   = tk ? m_tgt[i] : pc + 64'd4;
    return {hit, tk, t};
  endfunction

  // One clock: drive at negedge, compare just after, then apply the edge to the model.
  task automatic step(input logic r, input logic [XLEN-1:0] lpc, input logic en,
                      input logic [XLEN-1:0] upc, input logic tk,
                      input logic [XLEN-1:0] tgt, input logic mis);
    logic [65:0] e;
    @(negedge clk);
    rst = r;
    bus_a.lookup_pc = lpc;  bus_b.lookup_pc = lpc;
    bus_a.update_en = en;   bus_b.update_en = en;
    bus_a.update_pc = upc;  bus_b.update_pc = upc;
    bus_a.update_taken = tk;  bus_b.update_taken = tk;
    bus_a.update_target = tgt;  bus_b.update_target = tgt;
    bus_a.update_mispredict = mis;  bus_b.update_mispredict = mis;
    #1;
    exp_q.push_back(model_predict(lpc));
    e = exp_q.pop_front();
    check("hit_a",    64'(bus_a.pred_hit),    64'(e[65]));
    check("taken_a",  64'(bus_a.pred_taken),  64'(e[64]));
    check("target_a", bus_a.pred_target,      e[63:0]);
    check("hit_b",    64'(bus_b.pred_hit),    64'(e[65]));
    check("target_b", bus_b.pred_target,      e[63:0]);
    check("upd_a",    64'(bus_a.update_count),     64'(sat(m_upd, 64'hFFFF_FFFF)));
    check("mis_a",    64'(bus_a.mispredict_count), 64'(sat(m_mis, 64'hFFFF_FFFF)));
    check("upd_b",    64'(bus_b.update_count),     64'(sat(m_upd, 15)));
    check("mis_b",    64'(bus_b.mispredict_count), 64'(sat(m_mis, 15)));
    if (r) model_reset();
    else if (en) model_update(upc, tk, tgt, mis);
  endtask

  task automatic idle(input logic [XLEN-1:0] lpc);
    step(1'b0, lpc, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic upd(input logic [XLEN-1:0] lpc, input logic [XLEN-1:0] upc,
                     input logic tk, input logic [XLEN-1:0] tgt, input logic mis);
    step(1'b0, lpc, 1'b1, upc, tk, tgt, mis);
  endtask

  function automatic logic [XLEN-1:0] rand_pc();
    logic [XLEN-1:0] pc;
    pc = {$urandom(), $urandom()};
    pc[15:0] = {6'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    return pc;
  endfunction

  initial begin
    rst = 1'b1;
    bus_a.lookup_pc = '0;  bus_b.lookup_pc = '0;
    bus_a.update_en = 1'b0;  bus_b.update_en = 1'b0;
    bus_a.update_pc = '0;  bus_b.update_pc = '0;
    bus_a.update_taken = 1'b0;  bus_b.update_taken = 1'b0;
    bus_a.update_target = '0;  bus_b.update_target = '0;
    bus_a.update_mispredict = 1'b0;  bus_b.update_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // cold lookup, then allocation
    idle(64'h40);
    upd(64'h40, 64'h40, 1'b1, 64'h20, 1'b1);
    idle(64'h40);
    // saturate up, then hysteresis down to 00
    repeat (3) upd(64'h40, 64'h40, 1'b1, 64'h20, 1'b0);
    repeat (2) upd(64'h40, 64'h40, 1'b0, 64'h0, 1'b0);
    idle(64'h40);
    repeat (3) upd(64'h40, 64'h40, 1'b0, 64'h0, 1'b0);
    // not-taken miss and aliasing on index 0
    upd(64'h100, 64'h100, 1'b0, 64'h0, 1'b0);
    idle(64'h100);
    idle(64'h400);
    upd(64'h400, 64'h400, 1'b1, 64'h80, 1'b1);
    idle(64'h400);
    idle(64'h40);
    // same-cycle lookup/update conflict sees pre-update state
    upd(64'h40, 64'h40, 1'b1, 64'h20, 1'b0);
    upd(64'h40, 64'h40, 1'b0, 64'h0, 1'b1);
    idle(64'h40);
    // statistics saturation in the 4-bit instance
    for (int i = 0; i < 20; i++) upd(rand_pc(), rand_pc(), 1'($urandom_range(0, 1)), rand_pc(), i < 18);
    idle(64'h40);
    // reset wins over a simultaneous update
    step(1'b1, 64'h40, 1'b1, 64'h40, 1'b1, 64'h20, 1'b1);
    idle(64'h40);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 79) == 0), rand_pc(), 1'($urandom_range(0, 3) != 0), rand_pc(),
           1'($urandom_range(0, 2) != 0), {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
